counter_timer_multi: RTL and testbench
======================================

# counter_timer_multi

Parametrised multi-channel interval timer on a 32-bit Avalon-MM slave. It provides CHANNELS independent WIDTH-bit down-counters with one-shot or continuous mode, counter snapshot and per-channel interrupt enable. A shared programmable prescaler generates the count tick for all channels. It sits on the Nios II data bus and drives a single combined `irq` line.

## Interface
- CHANNELS, 4: number of timer channels, 1..16.
- WIDTH, 32: counter/period width, 8..32; registers are zero-extended to 32 bits on read.
- PERIOD_INIT, 49_999_999: reset value of every period register, truncated to WIDTH bits.
- PRESC_W, 16: prescaler width.
- clk in 1: single clock; all state is updated on its rising edge.
- reset_n in 1: reset is synchronous and active-low.
- address in AW = clog2(CHANNELS+1)+2: word address, decoded as {index, offset}.
- chipselect in 1: slave select.
- write_n in 1: active-low write strobe, qualified by chipselect.
- writedata in 32: write data.
- readdata out 32: registered read data.
- irq out 1: OR over all channels of (TO & ITO).

## Operation
- Register map for channel c (index = c):
  - offset 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - offset 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits 3:0 are stored as written.
  - offset 2 PERIOD.
  - offset 3 SNAP: any write captures the counter; a read returns the captured value.
- Global block at index = CHANNELS:
  - offset 0 IRQ_PEND: bit c = TO_c & ITO_c. Read-only.
  - offset 1 PRESCALE: PRESC_W bits.
  - Other offsets, and indices above CHANNELS, read 0 and ignore writes.
- Prescaler:
  - presc_cnt counts 0..PRESCALE, then wraps to 0.
  - tick = (presc_cnt == PRESCALE). PRESCALE = 0 gives a tick every cycle.
  - A write to PRESCALE also clears presc_cnt.
- Channel update, in priority order:
  1. PERIOD write: count is loaded with writedata[WIDTH-1:0], and RUN is cleared in the same cycle.
  2. CONTROL write with STOP=1: RUN is cleared. STOP beats START.
  3. CONTROL write with START=1: RUN is set. The counter is not reloaded.
  4. RUN & tick & count==0: count reloads from PERIOD and the timeout event fires. If CONT=0, RUN is cleared.
  5. RUN & tick & count!=0: count is decremented.
- Timeout period is (PERIOD+1)·(PRESCALE+1) clk cycles.
- TO is set on the timeout event. If a STATUS write and a timeout event occur in the same cycle, the set wins.
- A snapshot write and a decrement in the same cycle capture the pre-decrement value.
- PERIOD = 0 in continuous mode fires a timeout event on every tick.

## Timing
- Reset values, applied at a clk edge while reset_n=0:
  - count = PERIOD = PERIOD_INIT
  - RUN = TO = 0, CONTROL = 0, SNAP = 0
  - presc_cnt = 0, PRESCALE = 0
  - readdata = 0, irq = 0
- readdata is registered from `address` every cycle, independent of chipselect. Read latency is 1 cycle, with no wait states.
- Writes take effect at the edge where chipselect & ~write_n is sampled.
- irq is combinational from registered TO/ITO:
  - It rises in the cycle after the edge that sets TO.
  - It falls in the cycle after a STATUS clear, or after ITO is written to 0.
- Reset asserted mid-count: all state returns to its reset values at the next edge. There is no pending event or interrupt afterwards.

## Structure
- `counter_timer_pkg` holds:
  - offset constants: OFF_STATUS=0, OFF_CONTROL=1, OFF_PERIOD=2, OFF_SNAP=3, OFF_IRQ_PEND=0, OFF_PRESCALE=1
  - control bit indices: CTL_ITO=0, CTL_CONT=1, CTL_START=2, CTL_STOP=3
  - a status bit typedef
- Sub-module `counter_timer_chan` is generated CHANNELS times. It holds count, PERIOD, CONTROL, TO, RUN and SNAP, and takes decoded write strobes plus tick.
- The top level contains the prescaler, address decode, read mux and irq reduction.

## Test plan
- Reset, then read every register -> PERIOD = PERIOD_INIT (truncated to WIDTH), all others 0, irq = 0.
- CHANNELS=4; ch1 PERIOD=9, PRESCALE=0, CONTROL=0x7 -> TO1 sets every 10 cycles; irq high the cycle after; IRQ_PEND=0x2; STATUS1 write drops irq the next cycle.
- ch0 PERIOD=4, CONTROL=0x5 (one-shot) -> exactly one timeout after 5 ticks; RUN0 reads 0 afterwards; count stays at 4.
- PRESCALE=3, ch2 PERIOD=2, continuous -> timeouts every 12 cycles; a PRESCALE write mid-run restarts the tick phase.
- STATUS write in the same cycle as a timeout -> TO stays 1. CONTROL=0xC -> RUN=0. PERIOD write while running -> RUN=0 and SNAP capture returns the new period.
- Reset pulse while ch3 is 2 cycles from timeout -> no TO, irq stays 0, count = PERIOD_INIT.

Source files
------------

// File: rtl/counter_timer_pkg.sv
// Shared constants and types for the multi-channel interval timer.
package counter_timer_pkg;

  // Register offsets inside a channel block and inside the global block
  localparam logic [1:0] OFF_STATUS   = 2'd0;
  localparam logic [1:0] OFF_CONTROL  = 2'd1;
  localparam logic [1:0] OFF_PERIOD   = 2'd2;
  localparam logic [1:0] OFF_SNAP     = 2'd3;
  localparam logic [1:0] OFF_IRQ_PEND = 2'd0;
  localparam logic [1:0] OFF_PRESCALE = 2'd1;

  // CONTROL register bit positions
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS register layout: bit0 TO, bit1 RUN
  typedef struct packed {
    logic run;
    logic to;
  } status_t;

  // Zero-extend a status value to a bus word
  function automatic logic [31:0] status_word(input status_t s);
    return {30'd0, s};
  endfunction

endpackage

// File: rtl/counter_timer_multi_if.sv
// Avalon-MM slave bus bundle for the timer, plus its interrupt line.
interface counter_timer_multi_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/counter_timer_chan.sv
// One timer channel: down-counter, period, control, timeout flag and snapshot.
module counter_timer_chan
  import counter_timer_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] PERIOD_INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_s,
  input  logic             wr_status_s,
  input  logic             wr_control_s,
  input  logic             wr_period_s,
  input  logic             wr_snap_s,
  input  logic [31:0]      writedata,
  output logic             to_r,
  output logic             run_r,
  output logic [3:0]       ctl_r,
  output logic [WIDTH-1:0] period_r,
  output logic [WIDTH-1:0] snap_r
);

  logic [WIDTH-1:0] count_r;
  logic             timeout_s;
  logic             dec_s;
  logic             run_nxt_s;

  // Resolve the prioritised channel action for this cycle
  always_comb begin
    timeout_s = 1'b0;
    dec_s     = 1'b0;
    run_nxt_s = run_r;
    if (wr_period_s) begin
      run_nxt_s = 1'b0;
    end else if (wr_control_s && writedata[CTL_STOP]) begin
      run_nxt_s = 1'b0;
    end else if (wr_control_s && writedata[CTL_START]) begin
      run_nxt_s = 1'b1;
    end else if (run_r && tick_s) begin
      if (count_r == {WIDTH{1'b0}}) begin
        timeout_s = 1'b1;
        run_nxt_s = ctl_r[CTL_CONT];
      end else begin
        dec_s = 1'b1;
      end
    end else begin
      run_nxt_s = run_r;
    end
  end

  // Channel state registers; a timeout beats a same-cycle STATUS clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r  <= PERIOD_INIT;
      period_r <= PERIOD_INIT;
      ctl_r    <= 4'd0;
      to_r     <= 1'b0;
      run_r    <= 1'b0;
      snap_r   <= {WIDTH{1'b0}};
    end else begin
      run_r  <= run_nxt_s;
      ctl_r  <= wr_control_s ? writedata[3:0] : ctl_r;
      snap_r <= wr_snap_s ? count_r : snap_r;
      if (wr_period_s) begin
        period_r <= writedata[WIDTH-1:0];
        count_r  <= writedata[WIDTH-1:0];
      end else if (timeout_s) begin
        count_r <= period_r;
      end else if (dec_s) begin
        count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
      if (timeout_s) begin
        to_r <= 1'b1;
      end else if (wr_status_s) begin
        to_r <= 1'b0;
      end else begin
        to_r <= to_r;
      end
    end
  end

endmodule

// File: rtl/counter_timer_multi.sv
// Multi-channel interval timer: prescaler, address decode, read mux, irq.
module counter_timer_multi
  import counter_timer_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 32,
  parameter logic [31:0] PERIOD_INIT = 32'd49_999_999,
  parameter int          PRESC_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  counter_timer_multi_if.slave  bus
);

  localparam int IW = $clog2(CHANNELS + 1);
  localparam int AW = IW + 2;

  logic [IW-1:0]       idx_s;
  logic [1:0]          off_s;
  logic                wr_en_s;
  logic                glb_sel_s;
  logic                tick_s;
  logic [PRESC_W-1:0]  presc_cnt_r;
  logic [PRESC_W-1:0]  prescale_r;
  logic [CHANNELS-1:0] to_s;
  logic [CHANNELS-1:0] run_s;
  logic [CHANNELS-1:0] ito_s;
  logic [CHANNELS-1:0] pend_s;
  logic [31:0]         chan_rd_s [CHANNELS];
  logic [31:0]         glb_rd_s;
  logic [31:0]         rd_s;

  assign idx_s     = bus.address[AW-1:2];
  assign off_s     = bus.address[1:0];
  assign wr_en_s   = bus.chipselect & ~bus.write_n;
  assign glb_sel_s = (idx_s == IW'(CHANNELS));
  assign tick_s    = (presc_cnt_r == prescale_r);

  // Shared prescaler; writing PRESCALE restarts the tick phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_cnt_r <= {PRESC_W{1'b0}};
      prescale_r  <= {PRESC_W{1'b0}};
    end else if (wr_en_s && glb_sel_s && (off_s == OFF_PRESCALE)) begin
      presc_cnt_r <= {PRESC_W{1'b0}};
      prescale_r  <= bus.writedata[PRESC_W-1:0];
    end else if (tick_s) begin
      presc_cnt_r <= {PRESC_W{1'b0}};
    end else begin
      presc_cnt_r <= presc_cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             sel_s;
    logic [3:0]       ctl_s;
    logic [WIDTH-1:0] period_s;
    logic [WIDTH-1:0] snap_s;
    logic [31:0]      rd_word_s;

    assign sel_s = wr_en_s & (idx_s == IW'(c));

    counter_timer_chan #(
      .WIDTH       (WIDTH),
      .PERIOD_INIT (PERIOD_INIT[WIDTH-1:0])
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_s       (tick_s),
      .wr_status_s  (sel_s & (off_s == OFF_STATUS)),
      .wr_control_s (sel_s & (off_s == OFF_CONTROL)),
      .wr_period_s  (sel_s & (off_s == OFF_PERIOD)),
      .wr_snap_s    (sel_s & (off_s == OFF_SNAP)),
      .writedata    (bus.writedata),
      .to_r         (to_s[c]),
      .run_r        (run_s[c]),
      .ctl_r        (ctl_s),
      .period_r     (period_s),
      .snap_r       (snap_s)
    );

    assign ito_s[c] = ctl_s[CTL_ITO];

    // Readback word for this channel at the current offset
    always_comb begin
      rd_word_s = 32'd0;
      case (off_s)
        OFF_STATUS:  rd_word_s = status_word(status_t'{run: run_s[c], to: to_s[c]});
        OFF_CONTROL: rd_word_s = 32'(ctl_s);
        OFF_PERIOD:  rd_word_s = 32'(period_s);
        OFF_SNAP:    rd_word_s = 32'(snap_s);
        default:     rd_word_s = 32'd0;
      endcase
    end

    assign chan_rd_s[c] = rd_word_s;
  end

  assign pend_s  = to_s & ito_s;
  assign bus.irq = |pend_s;

  // Readback word for the global block
  always_comb begin
    glb_rd_s = 32'd0;
    case (off_s)
      OFF_IRQ_PEND: glb_rd_s = 32'(pend_s);
      OFF_PRESCALE: glb_rd_s = 32'(prescale_r);
      default:      glb_rd_s = 32'd0;
    endcase
  end

  // Full read mux; unmapped indices fall through to zero
  always_comb begin
    rd_s = glb_sel_s ? glb_rd_s : 32'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_s = rd_s | ((idx_s == IW'(c)) ? chan_rd_s[c] : 32'd0);
    end
  end

  // Registered read data, updated every cycle from the address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rd_s;
    end
  end

endmodule

// File: tb/tb_counter_timer_multi.sv
// Self-checking bench for counter_timer_multi: lockstep reference model plus
// directed scenarios and randomized bus traffic.
module tb_counter_timer_multi;

  localparam int          CH    = 4;
  localparam int          AW    = 5;
  localparam logic [31:0] PINIT = 32'd49_999_999;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  counter_timer_multi_if #(.AW(AW)) bus();

  counter_timer_multi #(
    .CHANNELS    (CH),
    .WIDTH       (32),
    .PERIOD_INIT (PINIT),
    .PRESC_W     (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, one entry per channel
  logic [31:0] m_cnt  [CH];
  logic [31:0] m_per  [CH];
  logic [31:0] m_snap [CH];
  logic        m_run  [CH];
  logic        m_to   [CH];
  logic [3:0]  m_ctl  [CH];
  logic [31:0] m_pc;
  logic [31:0] m_ps;
  logic [31:0] rd_exp;
  logic        irq_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] r;
    r = 32'd0;
    for (int c = 0; c < CH; c++) r[c] = m_to[c] & m_ctl[c][0];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx, input int off);
    if (idx < CH) begin
      case (off)
        0:       return {30'd0, m_run[idx], m_to[idx]};
        1:       return {28'd0, m_ctl[idx]};
        2:       return m_per[idx];
        default: return m_snap[idx];
      endcase
    end else if (idx == CH) begin
      if (off == 0) return m_pend();
      if (off == 1) return m_ps;
      return 32'd0;
    end
    return 32'd0;
  endfunction

  // Advance the model by one clock edge with the given bus inputs
  task automatic model_step(input logic rst, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    int   idx;
    int   off;
    logic tick;
    logic hit;
    logic ev;
    idx = int'(a) / 4;
    off = int'(a) % 4;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = PINIT; m_per[c] = PINIT; m_snap[c] = 32'd0;
        m_run[c] = 1'b0;  m_to[c]  = 1'b0;  m_ctl[c]  = 4'd0;
      end
      m_pc = 32'd0; m_ps = 32'd0; rd_exp = 32'd0; irq_exp = 1'b0;
      return;
    end
    rd_exp = model_read(idx, off);
    tick = (m_pc == m_ps);
    for (int c = 0; c < CH; c++) begin
      hit = we && (idx == c);
      ev  = 1'b0;
      if (hit && off == 3) m_snap[c] = m_cnt[c];
      if (hit && off == 2) begin
        m_per[c] = d; m_cnt[c] = d; m_run[c] = 1'b0;
      end else if (hit && off == 1 && d[3]) begin
        m_run[c] = 1'b0;
      end else if (hit && off == 1 && d[2]) begin
        m_run[c] = 1'b1;
      end else if (m_run[c] && tick) begin
        if (m_cnt[c] == 32'd0) begin
          m_cnt[c] = m_per[c];
          ev = 1'b1;
          if (!m_ctl[c][1]) m_run[c] = 1'b0;
        end else begin
          m_cnt[c] = m_cnt[c] - 32'd1;
        end
      end
      if (hit && off == 1) m_ctl[c] = d[3:0];
      if (ev) m_to[c] = 1'b1;
      else if (hit && off == 0) m_to[c] = 1'b0;
    end
    if (we && idx == CH && off == 1) begin
      m_ps = d & 32'h0000_FFFF;
      m_pc = 32'd0;
    end else if (tick) begin
      m_pc = 32'd0;
    end else begin
      m_pc = m_pc + 32'd1;
    end
    irq_exp = |m_pend();
  endtask

  // One bus cycle: drive, step model, clock, then compare readdata and irq
  task automatic bus_cycle(input logic cs, input logic wn, input logic [AW-1:0] a, input logic [31:0] d);
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
    model_step(reset_n, cs & ~wn, a, d);
    @(posedge clk);
    #1;
    check_val("rdata", bus.readdata, rd_exp);
    check_val("irq", {31'd0, bus.irq}, {31'd0, irq_exp});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    bus_cycle(1'b0, 1'b1, a, 32'd0);
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b1, 5'd16, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    bit          found;

    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 5'd0;
    bus.writedata  = 32'd0;

    // Reset and read back the whole address space
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) rd(AW'(a), d);
    rd(5'd2, d);
    check_val("rst_period0", d, PINIT);
    check_val("rst_irq", {31'd0, bus.irq}, 32'd0);

    // ch1 continuous, PERIOD=9, PRESCALE=0: timeout every 10 cycles
    wr(5'd6, 32'd9);
    wr(5'd17, 32'd0);
    wr(5'd5, 32'd7);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      idle(1);
      if (bus.irq) begin found = 1'b1; lat = i; end
    end
    check_val("to1_latency", 32'(lat), 32'd10);
    rd(5'd16, d);
    check_val("irq_pend", d, 32'd2);
    wr(5'd4, 32'd0);
    check_val("irq_clear", {31'd0, bus.irq}, 32'd0);
    idle(25);
    wr(5'd5, 32'hC);
    rd(5'd4, d);
    check_val("stop_run", {31'd0, d[1]}, 32'd0);
    wr(5'd4, 32'd0);

    // ch0 one-shot, PERIOD=4
    wr(5'd2, 32'd4);
    wr(5'd1, 32'd5);
    idle(20);
    rd(5'd0, d);
    check_val("oneshot_status", d, 32'd1);
    wr(5'd3, 32'd0);
    rd(5'd3, d);
    check_val("oneshot_count", d, 32'd4);
    wr(5'd1, 32'd0);
    wr(5'd0, 32'd0);

    // ch2 continuous, PERIOD=2, PRESCALE=3: 12-cycle timeout interval
    wr(5'd17, 32'd3);
    wr(5'd10, 32'd2);
    wr(5'd9, 32'd7);
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      idle(1);
      if (bus.irq) found = 1'b1;
    end
    check_val("presc_first_to", {31'd0, found}, 32'd1);
    wr(5'd8, 32'd0);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      idle(1);
      if (bus.irq) begin found = 1'b1; lat = i + 1; end
    end
    check_val("presc_interval", 32'(lat), 32'd12);
    idle(5);
    wr(5'd17, 32'd3);
    idle(30);

    // PERIOD write while running clears RUN and reloads the counter
    wr(5'd10, 32'd77);
    rd(5'd8, d);
    check_val("period_wr_run", {31'd0, d[1]}, 32'd0);
    wr(5'd11, 32'd0);
    rd(5'd11, d);
    check_val("period_wr_snap", d, 32'd77);
    wr(5'd9, 32'd0);
    wr(5'd8, 32'd0);

    // STATUS clear coinciding with a timeout (PERIOD=0 continuous)
    wr(5'd17, 32'd0);
    wr(5'd6, 32'd0);
    wr(5'd5, 32'd7);
    idle(3);
    wr(5'd4, 32'd0);
    rd(5'd4, d);
    check_val("to_set_wins", d, 32'd3);
    wr(5'd5, 32'hC);
    wr(5'd4, 32'd0);

    // Randomized bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rdat;
      rdat = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
      bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 31)), rdat);
    end

    // Reset pulse while ch3 is two edges from its timeout
    wr(5'd17, 32'd0);
    wr(5'd14, 32'd5);
    wr(5'd13, 32'd7);
    idle(4);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(10);
    check_val("rst_mid_irq", {31'd0, bus.irq}, 32'd0);
    rd(5'd12, d);
    check_val("rst_mid_status", d, 32'd0);
    wr(5'd15, 32'd0);
    rd(5'd15, d);
    check_val("rst_mid_count", d, PINIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
